// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle scheduler: arbitrates host target loads against manual inc/dec strobes and
// ramps the PWM duty toward the target one step per STEP_PERIODS period boundaries.
module pwm_ramp_ctrl #(
   parameter int MAX_DUTY     = 10,
   parameter int RESET_DUTY   = 5,
   parameter int STEP_PERIODS = 4,
   parameter int DUTY_W       = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DUTY_W-1:0] i_target,
   input  logic              i_target_valid,
   output logic              o_target_ready,
   input  logic              i_inc,
   input  logic              i_dec,
   input  logic              i_period_start,
   output logic [DUTY_W-1:0] o_duty,
   output logic              o_busy,
   output logic              o_at_target
);

   localparam int                CNT_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);
   localparam logic [DUTY_W-1:0] RST_D    = DUTY_W'(RESET_DUTY);
   localparam logic [DUTY_W-1:0] ONE_D    = DUTY_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_PERIODS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t            state;
   logic [DUTY_W-1:0] target;
   logic [CNT_W-1:0]  step_cnt;

   logic              req_valid;
   logic [DUTY_W-1:0] req_target;
   logic [DUTY_W-1:0] step_duty;

   // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
   always_comb begin
      req_valid  = 1'b0;
      req_target = o_duty;
      if (i_target_valid) begin
         // Host wins outright; a same-cycle button strobe is simply dropped.
         req_valid  = 1'b1;
         req_target = (i_target > MAX_D) ? MAX_D : i_target;
      end else if (i_inc && !i_dec && (o_duty < MAX_D)) begin
         req_valid  = 1'b1;
         req_target = o_duty + ONE_D;
      end else if (i_dec && !i_inc && (o_duty != '0)) begin
         req_valid  = 1'b1;
         req_target = o_duty - ONE_D;
      end
      step_duty = (target > o_duty) ? (o_duty + ONE_D) : (o_duty - ONE_D);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         o_duty   <= RST_D;
         target   <= RST_D;
         step_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  target <= req_target;
                  if (req_target != o_duty) begin
                     state    <= RAMP;
                     step_cnt <= '0;
                  end
               end
            end
            RAMP: begin
               // Duty moves only right after a period wrap, so the comparator never glitches.
               if (i_period_start) begin
                  if (step_cnt == CNT_LAST) begin
                     step_cnt <= '0;
                     o_duty   <= step_duty;
                     if (step_duty == target) state <= IDLE;
                  end else begin
                     step_cnt <= step_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_target_ready = (state == IDLE);
   assign o_busy         = (state == RAMP);
   assign o_at_target    = (o_duty == target);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: hand-computed duty/handshake expectations, checked at
// the falling edge, one linear sequence of steps.
module tb_pwm_ramp_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic [3:0] i_target;
   logic       i_target_valid;
   logic       o_target_ready;
   logic       i_inc;
   logic       i_dec;
   logic       i_period_start;
   logic [3:0] o_duty;
   logic       o_busy;
   logic       o_at_target;

   int checks = 0;
   int errors = 0;

   pwm_ramp_ctrl #(
      .MAX_DUTY    (10),
      .RESET_DUTY  (5),
      .STEP_PERIODS(4),
      .DUTY_W      (4)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_target      (i_target),
      .i_target_valid(i_target_valid),
      .o_target_ready(o_target_ready),
      .i_inc         (i_inc),
      .i_dec         (i_dec),
      .i_period_start(i_period_start),
      .o_duty        (o_duty),
      .o_busy        (o_busy),
      .o_at_target   (o_at_target)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clock edge; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic strobe();
      i_period_start = 1'b1;
      tick();
      i_period_start = 1'b0;
      tick();
   endtask

   task automatic status(input string tag, input int duty, input bit busy, input bit at_tgt);
      check({tag, ".duty"},  32'(o_duty),         32'(duty));
      check({tag, ".busy"},  32'(o_busy),         32'(busy));
      check({tag, ".ready"}, 32'(o_target_ready), 32'(!busy));
      check({tag, ".at"},    32'(o_at_target),    32'(at_tgt));
   endtask

   task automatic host(input logic [3:0] tgt);
      i_target       = tgt;
      i_target_valid = 1'b1;
      tick();
      i_target_valid = 1'b0;
   endtask

   initial begin
      i_rst_n        = 1'b0;
      i_target       = '0;
      i_target_valid = 1'b0;
      i_inc          = 1'b0;
      i_dec          = 1'b0;
      i_period_start = 1'b0;
      repeat (3) @(negedge i_clk);
      status("reset", 5, 1'b0, 1'b1);
      i_rst_n = 1'b1;

      // Idle for 50 cycles: nothing may move.
      for (int i = 0; i < 50; i++) begin
         tick();
         check("idle.duty", 32'(o_duty), 32'd5);
         check("idle.busy", 32'(o_busy), 32'd0);
      end
      status("idle_end", 5, 1'b0, 1'b1);

      // Host target 8: steps land on the 4th, 8th and 12th strobes.
      host(4'd8);
      status("ramp8.start", 5, 1'b1, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         strobe();
         check("ramp8.duty", 32'(o_duty), 32'(5 + k / 4));
         if (k < 12) check("ramp8.busy", 32'(o_busy), 32'd1);
      end
      status("ramp8.done", 8, 1'b0, 1'b1);

      // Host target 13 clamps to 10.
      host(4'd13);
      status("clamp.start", 8, 1'b1, 1'b0);
      repeat (7) strobe();
      status("clamp.mid", 9, 1'b1, 1'b0);
      strobe();
      status("clamp.done", 10, 1'b0, 1'b1);

      // Increment at MAX_DUTY is ignored.
      i_inc = 1'b1;
      tick();
      i_inc = 1'b0;
      status("inc_at_max", 10, 1'b0, 1'b1);

      // Decrement ramps to 9 after 4 strobes.
      i_dec = 1'b1;
      tick();
      i_dec = 1'b0;
      status("dec.start", 10, 1'b1, 1'b0);
      repeat (3) strobe();
      check("dec.hold", 32'(o_duty), 32'd10);
      strobe();
      status("dec.done", 9, 1'b0, 1'b1);

      // Host beats a same-cycle inc; a same-cycle period strobe is not counted.
      i_target       = 4'd2;
      i_target_valid = 1'b1;
      i_inc          = 1'b1;
      i_period_start = 1'b1;
      tick();
      i_target_valid = 1'b0;
      i_inc          = 1'b0;
      i_period_start = 1'b0;
      status("host_wins.start", 9, 1'b1, 1'b0);
      repeat (3) strobe();
      check("host_wins.no_early_step", 32'(o_duty), 32'd9);
      // Inc and host request during RAMP have no effect.
      i_inc = 1'b1;
      tick();
      i_inc          = 1'b0;
      i_target       = 4'd0;
      i_target_valid = 1'b1;
      tick();
      check("ramp.ready_low", 32'(o_target_ready), 32'd0);
      i_target_valid = 1'b0;
      strobe();
      check("host_wins.step1", 32'(o_duty), 32'd8);
      repeat (23) strobe();
      status("host_wins.near", 3, 1'b1, 1'b0);
      strobe();
      status("host_wins.done", 2, 1'b0, 1'b1);

      // Simultaneous inc and dec in IDLE cancel.
      i_inc = 1'b1;
      i_dec = 1'b1;
      tick();
      i_inc = 1'b0;
      i_dec = 1'b0;
      status("inc_dec", 2, 1'b0, 1'b1);

      // Ramp down to 0, then decrement at zero is ignored.
      host(4'd0);
      repeat (8) strobe();
      status("to_zero", 0, 1'b0, 1'b1);
      i_dec = 1'b1;
      tick();
      i_dec = 1'b0;
      status("dec_at_zero", 0, 1'b0, 1'b1);

      // Back to 5, then a host request equal to o_duty completes without a ramp.
      host(4'd5);
      repeat (20) strobe();
      status("to_five", 5, 1'b0, 1'b1);
      i_target       = 4'd5;
      i_target_valid = 1'b1;
      check("same.ready_before", 32'(o_target_ready), 32'd1);
      tick();
      i_target_valid = 1'b0;
      status("same.after", 5, 1'b0, 1'b1);
      tick();
      status("same.settled", 5, 1'b0, 1'b1);

      // Reset mid-ramp (duty 7, target 10) takes effect without a clock edge.
      host(4'd10);
      repeat (8) strobe();
      status("pre_reset", 7, 1'b1, 1'b0);
      i_rst_n = 1'b0;
      #1;
      status("async_reset", 5, 1'b0, 1'b1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      tick();
      status("post_reset", 5, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
